ps2_kbd_ctrl: RTL

Keyboard-side controller that sits directly behind the PS/2 byte receiver. It gates the receiver's enable, parses the raw scan-code byte stream (Set 2 prefixes E0/F0/E1, device response bytes) into single key events, and buffers those events in a small show-ahead FIFO with valid/ready output. Downstream logic (key mapping, UART/LED display) reads one complete event per handshake instead of tracking multi-byte sequences.

---
 rtl/ps2_kbd_pkg.sv | 54 +++++
 rtl/ps2_event_fifo.sv | 79 +++++++
 rtl/ps2_kbd_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, parser state encoding and event packing for the PS/2 keyboard controller.
// Scan-code Set 2 prefix and device-response byte values live here.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] PS2_BRK     = 8'hF0;
    localparam logic [7:0] PS2_PAUSE   = 8'hE1;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_BAT_ERR = 8'hFC;
    localparam logic [7:0] PS2_ERR_LO  = 8'h00;
    localparam logic [7:0] PS2_ERR_HI  = 8'hFF;

    localparam int         EV_W        = 10;
    // Pause is E1 followed by seven more bytes whose values carry no information.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    function automatic logic is_response(input logic [7:0] b);
        logic r;
        case (b)
            PS2_ACK, PS2_BAT_OK, PS2_ECHO, PS2_RESEND,
            PS2_BAT_ERR, PS2_ERR_LO, PS2_ERR_HI: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic kbd_event_t pack_event(input logic ext, input logic brk,
                                              input logic [7:0] code);
        kbd_event_t ev;
        ev.ext  = ext;
        ev.brk  = brk;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible combinationally from registered storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EV_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == (PW + 1)'(0));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);

        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: parses Set 2 byte sequences into single key events and
// buffers them in a show-ahead FIFO with valid/ready output.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    output logic                          rx_enable,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_extended,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          drop_tick
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    kbd_state_t  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        overflow_q, overflow_d;
    logic        drop_tick_q, drop_tick_d;

    kbd_state_t  fi_state_s;
    logic [2:0]  fi_skip_s;
    logic        fi_emit_s;

    logic        emit_s;
    kbd_event_t  ev_s;
    logic        drop_s;
    logic        push_s, pop_s;
    logic        full_s, empty_s;
    kbd_event_t  head_s;

    // Decision for a byte arriving as the first byte of a sequence (also used for resync).
    always_comb begin
        fi_state_s = ST_IDLE;
        fi_skip_s  = 3'd0;
        fi_emit_s  = 1'b0;
        if (rx_data == PS2_EXT) begin
            fi_state_s = ST_EXT;
        end else if (rx_data == PS2_BRK) begin
            fi_state_s = ST_BRK;
        end else if (rx_data == PS2_PAUSE) begin
            fi_state_s = ST_PAUSE;
            fi_skip_s  = PAUSE_SKIP;
        end else if (is_response(rx_data)) begin
            fi_emit_s = 1'b0;
        end else begin
            fi_emit_s = 1'b1;
        end
    end

    // Parser next-state, event emission and inter-byte timeout.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit_s  = 1'b0;
        drop_s  = 1'b0;
        ev_s    = pack_event(1'b0, 1'b0, rx_data);

        if ((state_q == ST_IDLE) || rx_done) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (rx_done) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = fi_state_s;
                    skip_d  = fi_skip_s;
                    emit_s  = fi_emit_s;
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                        drop_s  = 1'b1;
                    end else begin
                        emit_s  = 1'b1;
                        ev_s    = pack_event(1'b1, 1'b0, rx_data);
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if ((rx_data == PS2_EXT) || (rx_data == PS2_PAUSE)) begin
                        drop_s  = 1'b1;
                        state_d = fi_state_s;
                        skip_d  = fi_skip_s;
                    end else if (rx_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        emit_s  = 1'b1;
                        ev_s    = pack_event(1'b0, 1'b1, rx_data);
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if ((rx_data == PS2_EXT) || (rx_data == PS2_PAUSE) ||
                        (rx_data == PS2_BRK)) begin
                        drop_s  = 1'b1;
                        state_d = fi_state_s;
                        skip_d  = fi_skip_s;
                    end else begin
                        emit_s  = 1'b1;
                        ev_s    = pack_event(1'b1, 1'b1, rx_data);
                        state_d = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        emit_s  = 1'b1;
                        ev_s    = pack_event(1'b1, 1'b0, PS2_PAUSE);
                        state_d = ST_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d  = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
            drop_s  = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // FIFO handshake and sticky overflow; set wins over clear.
    always_comb begin
        pop_s  = ev_valid && ev_ready;
        push_s = emit_s && (!full_s || pop_s);
        if (emit_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        drop_tick_d = drop_s;
    end

    // Parser and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            skip_q      <= 3'd0;
            tmo_q       <= '0;
            overflow_q  <= 1'b0;
            drop_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            overflow_q  <= overflow_d;
            drop_tick_q <= drop_tick_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (ev_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (ev_count),
        .full      (full_s),
        .empty     (empty_s)
    );

    // A sequence already under way keeps the receiver enabled even with a full FIFO.
    assign rx_enable   = !full_s || (state_q != ST_IDLE);
    assign ev_valid    = !empty_s;
    assign ev_code     = head_s.code;
    assign ev_extended = head_s.ext;
    assign ev_break    = head_s.brk;
    assign overflow    = overflow_q;
    assign drop_tick   = drop_tick_q;

endmodule
